pc_redirect_ctrl: RTL

Controller for fetch-PC sequencing and control-flow redirection. Owns the program counter, advances it on accepted fetches, and applies the `jump`/`next` result resolved in EX by the branch resolution logic. On a redirect it issues pipeline flushes and buffers the target while instruction memory is busy. Sits between the EX-stage branch logic, the hazard unit and the IF stage; predicts not-taken.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/pc_redirect_ctrl_if.sv | 28 ++
 rtl/pc_redirect_ctrl_perf_ctr.sv | 17 +
 rtl/pc_redirect_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: PC geometry, reset address and the redirect controller state type.
package pipeline_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd1;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } redirect_state_t;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Fetch/redirect bus between EX branch logic, hazard unit, IF stage and the PC controller.
// Handshake: imem_ready=1 means IF accepts the address on pc this cycle; pc only counts as a
// request while fetch_valid=1, and the controller never changes pc while a request waits for imem_ready.
interface pc_redirect_ctrl_if;
  import pipeline_pkg::*;

  logic            stall;
  logic            imem_ready;
  logic            ex_valid;
  logic            ex_jump;
  logic [PC_W-1:0] ex_next;
  logic [PC_W-1:0] pc;
  logic            fetch_valid;
  logic            flush;
  logic            redirect_pending;
  redirect_state_t state;

  modport master (
    input  stall, imem_ready, ex_valid, ex_jump, ex_next,
    output pc, fetch_valid, flush, redirect_pending, state
  );

  modport slave (
    output stall, imem_ready, ex_valid, ex_jump, ex_next,
    input  pc, fetch_valid, flush, redirect_pending, state
  );

endinterface

// File: rtl/pc_redirect_ctrl_perf_ctr.sv
// 32-bit saturating event counter with enable, cleared by the asynchronous reset.
module redirect_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer with EX-resolved redirects, flush generation and a pending target held while imem is busy.
// Optional performance counters are built only when REDIRECT_PERF_EN is defined.
module pc_redirect_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  pc_redirect_ctrl_if.master bus
`ifdef REDIRECT_PERF_EN
  , output logic [31:0] perf_redirects
  , output logic [31:0] perf_bubbles
`endif
);

  redirect_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            redirect;
  logic            fetch_valid_c;
  logic            flush_c;
  logic            pending_c;

  assign redirect = bus.ex_valid & bus.ex_jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    fetch_valid_c = 1'b0;
    flush_c       = 1'b0;
    pending_c     = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        fetch_valid_c = 1'b1;
        // A redirect wins over stall: the stalled younger instructions are on the wrong path.
        if (redirect) begin
          flush_c = 1'b1;
          if (bus.imem_ready) begin
            pc_d = bus.ex_next;
          end else begin
            pend_d  = bus.ex_next;
            state_d = HOLD;
          end
        end else if (bus.imem_ready && !bus.stall) begin
          pc_d = pc_q + PC_INC;
        end
      end
      HOLD: begin
        // The old request is still outstanding, so pc stays put and its return is flushed.
        fetch_valid_c = 1'b1;
        flush_c       = 1'b1;
        pending_c     = 1'b1;
        if (redirect) begin
          pend_d = bus.ex_next;
        end
        if (bus.imem_ready) begin
          pc_d    = redirect ? bus.ex_next : pend_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign bus.pc               = pc_q;
  assign bus.fetch_valid      = fetch_valid_c;
  assign bus.flush            = flush_c;
  assign bus.redirect_pending = pending_c;
  assign bus.state            = state_q;

`ifdef REDIRECT_PERF_EN
  logic redirect_ev;
  logic bubble_ev;

  // A bubble is any cycle not delivering a useful new fetch: boot, flushed, or PC held in RUN.
  assign redirect_ev = redirect && (state_q != BOOT);
  assign bubble_ev   = !fetch_valid_c || flush_c ||
                       ((state_q == RUN) && !(bus.imem_ready && !bus.stall));

  redirect_perf_ctr u_redirect_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (redirect_ev),
    .count (perf_redirects)
  );

  redirect_perf_ctr u_bubble_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bubble_ev),
    .count (perf_bubbles)
  );
`endif

endmodule
